// File: rtl/pixel_stream_compare_pkg.sv
// Shared image-processing definitions: pixel width, mismatch counter width,
// frame-check state encoding and the absolute-difference helper.
// Imported by the compare top and by its bus interface.
package pixel_stream_compare_pkg;

  localparam int PIX_W = 8;
  localparam int CNT_W = 16;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Absolute difference kept one bit wider than a pixel, so the subtraction
  // never wraps.
  function automatic logic [PIX_W:0] abs_diff(input pixel_t a, input pixel_t b);
    if (a >= b) return {1'b0, a} - {1'b0, b};
    else        return {1'b0, b} - {1'b0, a};
  endfunction

endpackage

// File: rtl/pixel_stream_compare_if.sv
// Bus between a frame checker and its driver.
// master drives: start, ref_valid, ref_pixel, dut_pixel.
// slave drives : busy, done, pass, mismatch_cnt, first_err_*, max_diff.
interface pixel_stream_compare_if #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
);
  import pixel_stream_compare_pkg::*;

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic             start;
  logic             ref_valid;
  pixel_t           ref_pixel;
  pixel_t           dut_pixel;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] mismatch_cnt;
  logic             first_err_valid;
  logic [XW-1:0]    first_err_x;
  logic [YW-1:0]    first_err_y;
  pixel_t           max_diff;

  modport master (
    output start, ref_valid, ref_pixel, dut_pixel,
    input  busy, done, pass, mismatch_cnt, first_err_valid,
           first_err_x, first_err_y, max_diff
  );

  modport slave (
    input  start, ref_valid, ref_pixel, dut_pixel,
    output busy, done, pass, mismatch_cnt, first_err_valid,
           first_err_x, first_err_y, max_diff
  );

endinterface

// File: rtl/pixel_stream_compare_delay_line.sv
// pixel_delay_line: DEPTH-stage shift register of (valid, data) pairs.
// Ports: clk, rst (sync, active-high), clr (sync clear of all valids),
// in_valid/in_data enter stage 0, out_valid/out_data leave stage DEPTH-1.
module pixel_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld_q <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) vld_q[i] <= vld_q[i-1];
      vld_q[0] <= in_valid;
    end
  end

  // Data is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = DEPTH - 1; i > 0; i--) dat_q[i] <= dat_q[i-1];
    dat_q[0] <= in_data;
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/pixel_stream_compare.sv
// pixel_stream_compare: checks a pipelined stage frame by frame by comparing
// its output against the source pixel delayed by LAT cycles.
// Ports: clk, rst (sync, active-high), bus (slave): start/ref_valid/ref_pixel/
// dut_pixel in; busy/done/pass/mismatch_cnt/first_err_*/max_diff out.
module pixel_stream_compare
  import pixel_stream_compare_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int LAT   = 1,
  parameter int TOL   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  pixel_stream_compare_if.slave bus
);

  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [CW-1:0]    TOTAL_C = CW'(TOTAL);
  localparam logic [CW-1:0]    LAST_C  = CW'(TOTAL - 1);
  localparam logic [XW-1:0]    X_LAST  = XW'(IMG_W - 1);
  localparam logic [PIX_W:0]   TOL_C   = (PIX_W + 1)'(TOL);

  state_t           state_q, state_d;
  logic             clear, accept, cmp, last_cmp, mismatch;
  logic [CW-1:0]    acc_cnt_q, cmp_cnt_q;
  logic [XW-1:0]    x_q, fe_x_q;
  logic [YW-1:0]    y_q, fe_y_q;
  logic             d_valid;
  pixel_t           d_pixel;
  logic [PIX_W:0]   diff;
  logic             done_q, fe_vld_q;
  logic [CNT_W-1:0] mm_cnt_q;
  pixel_t           max_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // clear marks the cycle a new frame is launched; start seen in RUN is
  // ignored because only IDLE and DONE react to it.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          clear   = 1'b1;
        end
      end
      ST_RUN:  if (last_cmp) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept   = (state_q == ST_RUN) && bus.ref_valid && (acc_cnt_q < TOTAL_C);
  assign cmp      = (state_q == ST_RUN) && d_valid;
  assign last_cmp = cmp && (cmp_cnt_q == LAST_C);
  assign diff     = abs_diff(d_pixel, bus.dut_pixel);
  assign mismatch = diff > TOL_C;

  pixel_delay_line #(
    .DEPTH (LAT),
    .WIDTH (PIX_W)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .clr       (clear),
    .in_valid  (accept),
    .in_data   (bus.ref_pixel),
    .out_valid (d_valid),
    .out_data  (d_pixel)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_cnt_q <= '0;
      cmp_cnt_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      done_q    <= 1'b0;
      mm_cnt_q  <= '0;
      fe_vld_q  <= 1'b0;
      fe_x_q    <= '0;
      fe_y_q    <= '0;
      max_q     <= '0;
    end else begin
      // The final compare registers its result on the same edge that
      // enters DONE, so done and the complete results appear together.
      done_q <= last_cmp;
      if (accept) acc_cnt_q <= acc_cnt_q + 1'b1;
      if (cmp) begin
        cmp_cnt_q <= cmp_cnt_q + 1'b1;
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
        // diff never exceeds 255, so its low byte is the full value.
        if (diff[PIX_W-1:0] > max_q) max_q <= diff[PIX_W-1:0];
        if (mismatch) begin
          if (mm_cnt_q != {CNT_W{1'b1}}) mm_cnt_q <= mm_cnt_q + 1'b1;
          if (!fe_vld_q) begin
            fe_vld_q <= 1'b1;
            fe_x_q   <= x_q;
            fe_y_q   <= y_q;
          end
        end
      end
    end
  end

  assign bus.busy            = (state_q == ST_RUN);
  assign bus.done            = done_q;
  assign bus.pass            = (state_q == ST_DONE) && (mm_cnt_q == '0);
  assign bus.mismatch_cnt    = mm_cnt_q;
  assign bus.first_err_valid = fe_vld_q;
  assign bus.first_err_x     = fe_x_q;
  assign bus.first_err_y     = fe_y_q;
  assign bus.max_diff        = max_q;

endmodule

// File: tb/tb_pixel_stream_compare.sv
// Bench for pixel_stream_compare on a 4x2 frame: three instances
// (LAT=1/TOL=0, LAT=1/TOL=2, LAT=3/TOL=0) share one stimulus stream,
// gated by sel; expected frame results are queued and popped on done.
module tb_pixel_stream_compare;
  import pixel_stream_compare_pkg::*;

  localparam int W = 4;
  localparam int H = 2;

  typedef struct packed {
    logic        pass;
    logic [15:0] cnt;
    logic        fev;
    logic [1:0]  fx;
    logic        fy;
    logic [7:0]  maxd;
  } res_t;

  logic   clk = 1'b0;
  logic   rst;
  logic   start, ref_valid;
  pixel_t ref_pixel, dut_pixel;
  int     sel;
  int     lat;
  int     total, bad;
  bit     done_flag;
  pixel_t dpipe [4];
  res_t   exp_q [$];
  res_t   obs;
  logic   obs_busy, obs_done;

  always #5 clk = ~clk;

  pixel_stream_compare_if #(.IMG_W(W), .IMG_H(H)) if_a(), if_b(), if_c();

  assign if_a.start     = start && (sel == 0);
  assign if_b.start     = start && (sel == 1);
  assign if_c.start     = start && (sel == 2);
  assign if_a.ref_valid = ref_valid && (sel == 0);
  assign if_b.ref_valid = ref_valid && (sel == 1);
  assign if_c.ref_valid = ref_valid && (sel == 2);
  assign if_a.ref_pixel = ref_pixel;
  assign if_b.ref_pixel = ref_pixel;
  assign if_c.ref_pixel = ref_pixel;
  assign if_a.dut_pixel = dut_pixel;
  assign if_b.dut_pixel = dut_pixel;
  assign if_c.dut_pixel = dut_pixel;

  pixel_stream_compare #(.IMG_W(W), .IMG_H(H), .LAT(1), .TOL(0)) u_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  pixel_stream_compare #(.IMG_W(W), .IMG_H(H), .LAT(1), .TOL(2)) u_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));
  pixel_stream_compare #(.IMG_W(W), .IMG_H(H), .LAT(3), .TOL(0)) u_c (
    .clk(clk), .rst(rst), .bus(if_c.slave));

  always_comb begin
    obs_busy = if_a.busy;
    obs_done = if_a.done;
    obs = '{if_a.pass, if_a.mismatch_cnt, if_a.first_err_valid,
            if_a.first_err_x, if_a.first_err_y, if_a.max_diff};
    if (sel == 1) begin
      obs_busy = if_b.busy;
      obs_done = if_b.done;
      obs = '{if_b.pass, if_b.mismatch_cnt, if_b.first_err_valid,
              if_b.first_err_x, if_b.first_err_y, if_b.max_diff};
    end else if (sel == 2) begin
      obs_busy = if_c.busy;
      obs_done = if_c.done;
      obs = '{if_c.pass, if_c.mismatch_cnt, if_c.first_err_valid,
              if_c.first_err_x, if_c.first_err_y, if_c.max_diff};
    end
  end

  function automatic res_t mk(input logic p, input logic [15:0] c, input logic v,
                              input logic [1:0] x, input logic y, input logic [7:0] m);
    res_t r;
    r = '{p, c, v, x, y, m};
    return r;
  endfunction

  // mode 0: ramp 0..7, stage echoes ref; mode 1: ramp, stage returns 0x07
  // for pixel 5; mode 2: 255/0 alternating, stage returns 0.
  function automatic pixel_t pix_val(input int mode, input int i);
    if (mode == 2) return (i % 2 == 0) ? 8'd255 : 8'd0;
    return pixel_t'(i);
  endfunction

  function automatic pixel_t dut_val(input int mode, input int i, input pixel_t p);
    if (mode == 2) return 8'd0;
    if (mode == 1 && i == 5) return 8'h07;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock: drive inputs, model the checked stage (LAT cycles of delay),
  // then sample outputs 1 time unit after the edge.
  task automatic cyc(input logic st, input logic v, input pixel_t p, input pixel_t dv);
    start     = st;
    ref_valid = v;
    ref_pixel = p;
    dut_pixel = dpipe[lat-1];
    @(posedge clk);
    for (int k = 3; k > 0; k--) dpipe[k] = dpipe[k-1];
    dpipe[0] = dv;
    #1;
    if (obs_done) done_flag = 1'b1;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 20 && !done_flag; n++) cyc(0, 0, 8'd0, 8'd0);
    chk("done_seen", 32'(done_flag), 1);
  endtask

  task automatic run_frame(input int mode, input bit gap, input bit extra);
    pixel_t p;
    done_flag = 1'b0;
    cyc(1, 0, 8'd0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      p = pix_val(mode, i);
      cyc(0, 1, p, dut_val(mode, i, p));
      if (gap) cyc(i == 3, 0, 8'd0, 8'd0);  // start mid-RUN on one gap
    end
    if (extra) begin
      for (int i = 0; i < 3; i++) cyc(0, 1, 8'hEE, 8'hEE);
    end else begin
      // Final compare lands LAT cycles after the last accept; done follows.
      for (int i = 0; i < lat; i++) begin
        chk("done_early", 32'(obs_done), 0);
        chk("busy_run", 32'(obs_busy), 1);
        cyc(0, 0, 8'd0, 8'd0);
      end
      chk("done_on_time", 32'(obs_done), 1);
    end
    wait_done();
  endtask

  task automatic check_res(input string tag);
    res_t e;
    chk({tag, "_queue"}, exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_pass"}, 32'(obs.pass), 32'(e.pass));
      chk({tag, "_cnt"},  32'(obs.cnt),  32'(e.cnt));
      chk({tag, "_fev"},  32'(obs.fev),  32'(e.fev));
      chk({tag, "_fx"},   32'(obs.fx),   32'(e.fx));
      chk({tag, "_fy"},   32'(obs.fy),   32'(e.fy));
      chk({tag, "_maxd"}, 32'(obs.maxd), 32'(e.maxd));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(obs_busy), 0);
    chk({tag, "_done"}, 32'(obs_done), 0);
    chk({tag, "_pass"}, 32'(obs.pass), 0);
    chk({tag, "_cnt"},  32'(obs.cnt),  0);
    chk({tag, "_fev"},  32'(obs.fev),  0);
    chk({tag, "_fx"},   32'(obs.fx),   0);
    chk({tag, "_fy"},   32'(obs.fy),   0);
    chk({tag, "_maxd"}, 32'(obs.maxd), 0);
  endtask

  initial begin
    total = 0; bad = 0; sel = 0; lat = 1; done_flag = 1'b0;
    rst = 1'b1; start = 1'b0; ref_valid = 1'b0;
    ref_pixel = 8'd0; dut_pixel = 8'd0;
    for (int k = 0; k < 4; k++) dpipe[k] = 8'd0;

    repeat (3) cyc(0, 0, 8'd0, 8'd0);
    rst = 1'b0;
    check_zero("reset");

    // Clean ramp frame.
    exp_q.push_back(mk(1, 16'd0, 0, 2'd0, 1'b0, 8'd0));
    run_frame(0, 0, 0);
    check_res("clean");

    // rst wins over start in the same cycle; clears the DONE results.
    rst = 1'b1;
    cyc(1, 0, 8'd0, 8'd0);
    rst = 1'b0;
    chk("rst_vs_start_busy", 32'(obs_busy), 0);
    chk("rst_vs_start_pass", 32'(obs.pass), 0);

    // One corrupted pixel (index 5 -> x=1, y=1, diff 2).
    exp_q.push_back(mk(0, 16'd1, 1, 2'd1, 1'b1, 8'd2));
    run_frame(1, 0, 0);
    check_res("one_err");
    repeat (4) cyc(0, 1, 8'h55, 8'h00);
    chk("hold_cnt",  32'(obs.cnt),  1);
    chk("hold_maxd", 32'(obs.maxd), 2);
    chk("hold_busy", 32'(obs_busy), 0);

    // Gapped input, ignored mid-RUN start, dropped extra pixels.
    exp_q.push_back(mk(1, 16'd0, 0, 2'd0, 1'b0, 8'd0));
    run_frame(0, 1, 1);
    check_res("gaps");

    // Abort after 3 pixels with a mismatch already counted.
    done_flag = 1'b0;
    cyc(1, 0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) cyc(0, 1, pix_val(2, i), 8'd0);
    chk("pre_rst_cnt", 32'(obs.cnt), 1);
    rst = 1'b1;
    cyc(0, 0, 8'd0, 8'd0);
    rst = 1'b0;
    check_zero("mid_rst");
    repeat (6) cyc(0, 0, 8'd0, 8'd0);
    chk("no_done_after_rst", 32'(done_flag), 0);
    exp_q.push_back(mk(1, 16'd0, 0, 2'd0, 1'b0, 8'd0));
    run_frame(0, 0, 0);
    check_res("after_rst");

    // Tolerance 2 absorbs the single diff-2 pixel.
    sel = 1;
    exp_q.push_back(mk(1, 16'd0, 0, 2'd0, 1'b0, 8'd2));
    run_frame(1, 0, 0);
    check_res("tol2");

    // Three-cycle stage latency, 255/0 against all-zero output.
    sel = 2;
    lat = 3;
    exp_q.push_back(mk(0, 16'd4, 1, 2'd0, 1'b0, 8'd255));
    run_frame(2, 0, 0);
    check_res("lat3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_stream_compare.md
PIXEL_STREAM_COMPARE -- requirements
Module: pixel_stream_compare

Interface
REQ-001 Parameter IMG_W, default 256: pixels per line.
REQ-002 Parameter IMG_H, default 256: lines per frame.
REQ-003 Parameter LAT, default 1: cycles of latency of the checked stage (1..16).
REQ-004 Parameter TOL, default 0: largest absolute pixel difference that still counts as a match.
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle request to begin a frame check.
REQ-008 ref_valid  in  1  ref_pixel is valid this cycle; the same qualifier drives the checked stage.
REQ-009 ref_pixel  in  8  source pixel fed to the checked stage.
REQ-010 dut_pixel  in  8  checked-stage output, exactly LAT cycles behind ref_pixel.
REQ-011 busy  out  1  high in RUN.
REQ-012 done  out  1  one-cycle pulse on entry to DONE.
REQ-013 pass  out  1  valid in DONE: mismatch_cnt==0.
REQ-014 mismatch_cnt  out  16  count of mismatched pixels, saturating at 0xFFFF.
REQ-015 first_err_valid  out  1  at least one mismatch seen this frame.
REQ-016 first_err_x / first_err_y  out  clog2(IMG_W) / clog2(IMG_H)  column and row of first mismatch.
REQ-017 max_diff  out  8  largest absolute difference seen this frame.

Function
REQ-018 Three states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when compare count reaches IMG_W*IMG_H; DONE->RUN on start.
REQ-019 On every IDLE->RUN or DONE->RUN transition, all counters, result outputs and the delay line SHALL be cleared in that same cycle.
REQ-020 start in RUN SHALL be ignored.
REQ-021 ref_valid SHALL be accepted only in RUN and only while the accept count is below IMG_W*IMG_H; other ref_valid pulses are dropped.
REQ-022 Accepted (valid, pixel) pairs SHALL pass through a LAT-stage delay line so that the delayed pixel aligns with dut_pixel.
REQ-023 A compare SHALL occur on each cycle the delayed valid is high.
REQ-024 The difference is the 9-bit absolute difference |ref - dut|, computed without wrap; a mismatch is diff > TOL.
REQ-025 Compare position: x increments each compare and wraps at IMG_W-1 to 0 with y+1; the first pixel is (0,0).
REQ-026 The first mismatch SHALL latch x, y and first_err_valid; later mismatches do not overwrite them.
REQ-027 max_diff SHALL update to diff whenever diff > max_diff, on every compare including matches.
REQ-028 The mismatch result of the final pixel SHALL be included; done rises the cycle after the final compare.
REQ-029 Result outputs SHALL hold stable in DONE until the next start or rst.
REQ-030 Input gaps (ref_valid low) SHALL not alter results or positions.

Reset
REQ-031 rst SHALL force IDLE and clear busy, done, pass, mismatch_cnt, first_err_valid, first_err_x, first_err_y, max_diff and all delay-line valids to 0.
REQ-032 rst asserted mid-frame SHALL discard the partial frame, with no done pulse.
REQ-033 rst SHALL take priority over start in the same cycle.

Structure
REQ-034 The state encoding, the 8-bit pixel width constant and the mismatch counter width (16) SHALL live in a shared image-processing package.
REQ-035 The delay line SHALL be a sub-module pixel_delay_line, parameterised by depth and data width, with a valid bit per stage and a synchronous clear.

Verification (IMG_W=4, IMG_H=2, LAT=1, TOL=0 unless stated)
REQ-036 Stimulus: start, then ref pixels 0..7, dut = ref delayed 1 cycle.
  Response: done one cycle after the 8th compare, pass=1, mismatch_cnt=0, max_diff=0.
REQ-037 Stimulus: as REQ-036, but dut returns 0x07 for pixel 5.
  Response: mismatch_cnt=1, first_err (1,1), max_diff=2, pass=0.
REQ-038 Stimulus: TOL=2 with the REQ-037 stimulus.
  Response: pass=1, mismatch_cnt=0, max_diff=2, first_err_valid=0.
REQ-039 Stimulus: ref_valid every other cycle, plus start pulsed mid-RUN, plus 3 extra ref_valid after 8 accepted.
  Response: results identical to REQ-036.
REQ-040 Stimulus: rst after 3 pixels, then a fresh start and REQ-036 stimulus.
  Response: all outputs 0 after rst, no done pulse; the second run gives pass=1.
REQ-041 Stimulus: LAT=3, dut delayed 3 cycles, pixels 255,0 alternating, dut all 0.
  Response: mismatch_cnt=4, max_diff=255, first_err (0,0).
